// File: rtl/full_add64.sv
// Registered ripple-carry adder: {cOut, s} = x + y + cIn, one cycle of latency.
// The only state is the WIDTH+1 output register bits.
module full_add64 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cIn,
    output logic [WIDTH-1:0] s,
    output logic             cOut
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] propagate;
    logic [WIDTH-1:0] sumComb;
    logic [WIDTH-1:0] sumQ;
    logic             cOutQ;

    assign carry[0] = cIn;

    // One full-adder cell per bit; carry ripples from bit 0 to bit WIDTH-1.
    for (genvar i = 0; i < WIDTH; i++) begin : gCell
        assign propagate[i] = x[i] ^ y[i];
        assign sumComb[i]   = propagate[i] ^ carry[i];
        assign carry[i+1]   = (x[i] & y[i]) | (carry[i] & propagate[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sumQ  <= '0;
            cOutQ <= 1'b0;
        end else begin
            sumQ  <= sumComb;
            cOutQ <= carry[WIDTH];
        end
    end

    assign s    = sumQ;
    assign cOut = cOutQ;

endmodule

// File: tb/tb_full_add64.sv
// Scoreboard bench for full_add64: expected sums are queued when operands are driven
// and compared one cycle later, plus directed carry-chain and async-reset cases.
module tb_full_add64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] x;
    logic [63:0] y;
    logic        cIn;
    logic [63:0] s;
    logic        cOut;

    always #5 clk = ~clk;

    full_add64 #(
        .WIDTH(64)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .x    (x),
        .y    (y),
        .cIn  (cIn),
        .s    (s),
        .cOut (cOut)
    );

    int          checks = 0;
    int          errors = 0;
    logic [64:0] expQ[$];
    logic [64:0] lastExp;

    task automatic checkVal(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got cOut=%b s=%h, want cOut=%b s=%h",
                     tag, obs[64], obs[63:0], exp[64], exp[63:0]);
        end
    endtask

    // Drive operands now and queue the 65-bit reference sum.
    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic c);
        x   = a;
        y   = b;
        cIn = c;
        expQ.push_back({1'b0, a} + {1'b0, b} + {64'd0, c});
    endtask

    // Advance one edge, then pop the oldest expectation and compare.
    task automatic stepCheck(input string tag);
        logic [64:0] e;
        @(posedge clk);
        #1;
        e = (expQ.size() != 0) ? expQ.pop_front() : 65'bx;
        lastExp = e;
        checkVal(tag, {cOut, s}, e);
    endtask

    logic [63:0] dirX[7];
    logic [63:0] dirY[7];
    logic        dirC[7];

    initial begin
        dirX = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'h5555_5555_5555_5555,
                 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                 64'hFFFF_FFFF_FFFF_FFFF};
        dirY = '{64'h1, 64'h1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
        dirC = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        x     = 64'h1234_5678_9ABC_DEF0;
        y     = 64'h0FED_CBA9_8765_4321;
        cIn   = 1'b1;

        // Outputs stay cleared across edges while reset is held.
        @(posedge clk);
        #1;
        checkVal("resetState", {cOut, s}, 65'd0);
        @(posedge clk);
        #1;
        checkVal("resetHeld", {cOut, s}, 65'd0);

        #2;
        rst_n = 1'b1;
        drive(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, 1'b0);
        stepCheck("firstAfterRst");

        for (int i = 0; i < 7; i++) begin
            drive(dirX[i], dirY[i], dirC[i]);
            stepCheck($sformatf("directed%0d", i));
        end

        // Input changes between edges must not reach the outputs.
        x   = ~x;
        y   = 64'h0123_4567_89AB_CDEF;
        cIn = ~cIn;
        #2;
        checkVal("holdBetweenEdges", {cOut, s}, lastExp);

        // Mid-operation reset clears the registered result without a clock edge.
        drive(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0003, 1'b1);
        stepCheck("preRst");
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("asyncRst", {cOut, s}, 65'd0);
        x   = 64'hFFFF_0000_FFFF_0000;
        y   = 64'h0001_0000_0001_0000;
        cIn = 1'b0;
        @(posedge clk);
        #1;
        checkVal("rstBlocksEdge", {cOut, s}, 65'd0);
        #2;
        rst_n = 1'b1;
        drive(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b1);
        stepCheck("releaseCapture");

        // Back-to-back random vectors, one per cycle.
        for (int i = 0; i < 1200; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1, 0)));
            stepCheck("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/full_add64.md
FULL_ADD64 -- requirements
Module: full_add64

Interface
REQ-001 Parameter: WIDTH, default 64, operand/sum width; only 64 is required to be supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: x  input  64  addend A, unsigned.
REQ-005 Port: y  input  64  addend B, unsigned.
REQ-006 Port: cIn  input  1  carry into bit 0.
REQ-007 Port: s  output  64  registered sum, bits [63:0].
REQ-008 Port: cOut  output  1  registered carry out of bit 63.
REQ-009 Port order SHALL be clk, rst_n, x, y, cIn, s, cOut.

Function
REQ-010 Datapath SHALL be a ripple-carry chain of 64 one-bit full-adder cells; cell i takes x[i], y[i], carry c[i] and produces sum bit and c[i+1]; c[0] = cIn.
REQ-011 Each cell: sum = a XOR b XOR cin; cout = (a AND b) OR (cin AND (a XOR b)).
REQ-012 Combinational result SHALL equal {cOut, s} = x + y + cIn as a 65-bit unsigned sum; no truncation of the carry.
REQ-013 s and cOut SHALL be registered: values sampled on rising edge N appear on outputs after that edge and hold until the next edge (latency 1 cycle).
REQ-014 No handshake; a new operand set is accepted every cycle (throughput 1/cycle).
REQ-015 Inputs changing between edges SHALL NOT affect outputs until the next rising edge.
REQ-016 Wrap-around: all-ones + all-ones + 1 SHALL give s = all-ones, cOut = 1; no saturation, no overflow flag.
REQ-017 Full 64-bit carry propagation (e.g. all-ones + 0 + 1) SHALL resolve within one clock period; the design's critical path is the 64-cell chain.
REQ-018 Design SHALL contain no state other than the 65 output register bits.

Reset
REQ-019 While rst_n = 0, s SHALL be 64'h0 and cOut SHALL be 0, immediately and independent of clk.
REQ-020 Reset assertion mid-operation SHALL discard the registered result at once; no pending result is carried across reset.
REQ-021 After rst_n rises, the first rising clk edge SHALL capture the current x, y, cIn normally.

Verification
REQ-022 x=64'hFFFFFFFFFFFFFFFE, y=64'h0000000000000001, cIn=0, one edge -> s=64'hFFFFFFFFFFFFFFFF, cOut=0.
REQ-023 Same x, y with cIn=1, one edge -> s=64'h0000000000000000, cOut=1 (full-chain ripple).
REQ-024 x=64'h5555555555555555, y=64'hAAAAAAAAAAAAAAAA, cIn=0 -> s=64'hFFFFFFFFFFFFFFFF, cOut=0; with cIn=1 -> s=0, cOut=1.
REQ-025 x=y=64'hFFFFFFFFFFFFFFFF, cIn=1 -> s=64'hFFFFFFFFFFFFFFFF, cOut=1; x=y=0, cIn=0 -> s=0, cOut=0.
REQ-026 Load nonzero result, pull rst_n low between edges -> s=0, cOut=0 without a clock edge; release, next edge -> current-input sum.
REQ-027 Back-to-back: new random x, y, cIn each cycle (>=1000 vectors) -> each output equals the 65-bit reference sum of the previous cycle's inputs.
